// File: rtl/prodsum_batch_seq.sv
// Batch/product read sequencer: walks the LUT contiguously for num_bats x num_prods
// products, then drains the per-batch results and reports completion.
module prodsum_batch_seq #(
   parameter int ADR_W     = 10,
   parameter int CNT_W     = 10,
   parameter int DRAIN_CYC = 64
) (
   input  logic             s_clk,
   input  logic             reset_in,
   input  logic             start,
   input  logic             abort,
   input  logic             stall,
   input  logic [CNT_W-1:0] num_bats,
   input  logic [CNT_W-1:0] num_prods,
   input  logic             res_valid,
   output logic [ADR_W-1:0] data_lut_adr,
   output logic             datavalid_out,
   output logic             clear_ena,
   output logic             trunc_ena,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic             overrun,
   output logic [CNT_W-1:0] res_count
);

   localparam int DC_W = $clog2(DRAIN_CYC) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] nb, np, b, p, res_nxt;
   logic [DC_W-1:0]  dcnt;
   logic             accept, issue, last_p, last_b;
   logic             res_en, res_ovf, drain_ok, drain_exp;

   always_comb begin
      accept    = (state == IDLE) && start && !abort;
      issue     = (state == ISSUE) && !stall;
      last_p    = (p == np - CNT_W'(1));
      last_b    = (b == nb - CNT_W'(1));
      res_en    = res_valid && (state != IDLE);
      res_ovf   = res_en && (res_count == nb);
      res_nxt   = (res_en && !res_ovf) ? res_count + CNT_W'(1) : res_count;
      // a result landing this cycle counts toward the drain exit
      drain_ok  = (res_nxt == nb);
      drain_exp = (dcnt == DC_W'(DRAIN_CYC - 1));
      state_nxt = state;
      unique case (state)
         IDLE:  if (accept)
                   state_nxt = (num_bats == '0 || num_prods == '0) ? FIN : ISSUE;
         ISSUE: if (issue && last_p && last_b) state_nxt = DRAIN;
         DRAIN: if (drain_ok || drain_exp) state_nxt = FIN;
         FIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   always_ff @(posedge s_clk) begin
      if (!reset_in) begin
         state         <= IDLE;
         nb            <= '0;
         np            <= '0;
         b             <= '0;
         p             <= '0;
         dcnt          <= '0;
         data_lut_adr  <= '0;
         datavalid_out <= 1'b0;
         clear_ena     <= 1'b0;
         trunc_ena     <= 1'b0;
         timeout       <= 1'b0;
         overrun       <= 1'b0;
         res_count     <= '0;
      end else begin
         state         <= state_nxt;
         datavalid_out <= issue && !abort;
         clear_ena     <= issue && !abort && (p == '0);
         trunc_ena     <= issue && !abort && last_p;
         dcnt          <= (state == DRAIN) ? dcnt + DC_W'(1) : '0;
         if (accept) begin
            nb           <= num_bats;
            np           <= num_prods;
            b            <= '0;
            p            <= '0;
            data_lut_adr <= '0;
            res_count    <= '0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
         end else begin
            res_count <= res_nxt;
            if (res_ovf) overrun <= 1'b1;
            if (state == DRAIN && !drain_ok && drain_exp && !abort) timeout <= 1'b1;
            if (issue) begin
               data_lut_adr <= data_lut_adr + ADR_W'(1);
               if (last_p) begin
                  p <= '0;
                  b <= b + CNT_W'(1);
               end else begin
                  p <= p + CNT_W'(1);
               end
            end
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == FIN) && !abort;

endmodule

// File: tb/tb_prodsum_batch_seq.sv
// Directed bench: expected read stream queued at start, checked as valids emerge.
module tb_prodsum_batch_seq;

   logic       s_clk = 1'b0;
   logic       reset_in, start, abort, stall, res_valid;
   logic [9:0] num_bats, num_prods;
   logic [9:0] data_lut_adr, res_count;
   logic       datavalid_out, clear_ena, trunc_ena, busy, done, timeout, overrun;

   int         checks = 0;
   int         errors = 0;
   int         cyc;
   logic [11:0] exp_q[$];
   logic [11:0] rec;
   logic [9:0]  prev_adr = '0;

   always #5 s_clk = ~s_clk;

   prodsum_batch_seq dut (
      .s_clk(s_clk), .reset_in(reset_in), .start(start), .abort(abort), .stall(stall),
      .num_bats(num_bats), .num_prods(num_prods), .res_valid(res_valid),
      .data_lut_adr(data_lut_adr), .datavalid_out(datavalid_out), .clear_ena(clear_ena),
      .trunc_ena(trunc_ena), .busy(busy), .done(done), .timeout(timeout),
      .overrun(overrun), .res_count(res_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // each valid carries the address presented one cycle earlier
   always @(negedge s_clk) begin
      if (datavalid_out) begin
         if (exp_q.size() == 0) chk("dv_unexpected", 32'(datavalid_out), 32'd0);
         else begin
            rec = exp_q.pop_front();
            chk("dv_record", 32'({prev_adr, clear_ena, trunc_ena}), 32'(rec));
         end
      end
      prev_adr = data_lut_adr;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge s_clk);
         #1;
      end
   endtask

   task automatic start_run(input int nb, input int np, input int npush);
      for (int i = 0; i < npush; i++)
         exp_q.push_back({10'(i % 1024), (i % np) == 0, (i % np) == np - 1});
      num_bats  = 10'(nb);
      num_prods = 10'(np);
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_q(input string tag, input int budget, output int n);
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic res_pulses(input int n);
      res_valid = 1'b1;
      step(n);
      res_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_in = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0; res_valid = 1'b0;
      num_bats = '0; num_prods = '0;
      step(3);
      chk("rst_adr", 32'(data_lut_adr), 32'd0);
      chk("rst_flags", 32'({datavalid_out, clear_ena, trunc_ena, busy, done, timeout, overrun}), 32'd0);
      chk("rst_rcnt", 32'(res_count), 32'd0);
      reset_in = 1'b1;
      step();

      // basic 2x3 run; inputs change after latch
      start_run(2, 3, 6);
      num_bats = 10'd7; num_prods = 10'd9;
      chk("t1_busy", 32'(busy), 32'd1);
      wait_q("t1_stream", 20, cyc);
      chk("t1_span", 32'(cyc), 32'd6);
      res_pulses(2);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_timeout", 32'(timeout), 32'd0);
      chk("t1_rcnt", 32'(res_count), 32'd2);
      step();
      chk("t1_done_len", 32'({done, busy}), 32'd0);
      res_pulses(2);
      chk("idle_res_ignored", 32'({overrun, res_count}), 32'd2);

      // stall holds address 3 for three cycles
      start_run(2, 3, 6);
      step(3);
      stall = 1'b1;
      chk("t2_adr_a", 32'(data_lut_adr), 32'd3);
      step();
      start = 1'b1;
      chk("t2_gap_a", 32'({data_lut_adr, datavalid_out}), 32'({10'd3, 1'b0}));
      step();
      start = 1'b0;
      chk("t2_gap_b", 32'({data_lut_adr, datavalid_out}), 32'({10'd3, 1'b0}));
      step();
      chk("t2_gap_c", 32'({data_lut_adr, datavalid_out}), 32'({10'd3, 1'b0}));
      stall = 1'b0;
      wait_q("t2_stream", 20, cyc);
      chk("t2_span", 32'(cyc), 32'd3);
      res_pulses(2);
      chk("t2_end", 32'({done, timeout, overrun, res_count}), 32'({3'b100, 10'd2}));
      step();

      // drain timeout
      start_run(1, 4, 4);
      wait_q("t3_stream", 20, cyc);
      cyc = 0;
      while (!done && cyc < 200) begin
         step();
         cyc++;
      end
      chk("t3_drain_cycles", 32'(cyc), 32'd64);
      chk("t3_timeout", 32'(timeout), 32'd1);
      chk("t3_rcnt", 32'(res_count), 32'd0);
      step(2);
      chk("t3_hold", 32'({busy, timeout}), 32'b01);

      // zero counts go straight to FIN
      start_run(0, 5, 0);
      chk("t4a_fin", 32'({busy, done, timeout}), 32'b110);
      step();
      chk("t4a_idle", 32'({busy, done}), 32'd0);
      start_run(3, 0, 0);
      chk("t4b_fin", 32'({busy, done}), 32'b11);
      step();
      chk("t4b_idle", 32'({busy, done}), 32'd0);
      abort = 1'b1;
      start_run(2, 3, 0);
      abort = 1'b0;
      chk("abort_beats_start", 32'(busy), 32'd0);
      step(2);

      // address wrap across 1536 contiguous reads
      start_run(3, 512, 1536);
      wait_q("t5_stream", 2000, cyc);
      chk("t5_span", 32'(cyc), 32'd1536);
      res_pulses(3);
      chk("t5_end", 32'({done, timeout, res_count}), 32'({2'b10, 10'd3}));
      step();

      // abort on the fourth issue
      start_run(2, 3, 3);
      step(3);
      chk("t6_adr", 32'(data_lut_adr), 32'd3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t6_abort", 32'({busy, datavalid_out, done}), 32'd0);
      chk("t6_queue", 32'(exp_q.size()), 32'd0);
      step();
      chk("t6_no_done", 32'({busy, done}), 32'd0);

      // overrun from a third result
      start_run(2, 3, 6);
      wait_q("t7_stream", 20, cyc);
      res_pulses(3);
      chk("t7_overrun", 32'({busy, overrun, res_count}), 32'({2'b01, 10'd2}));
      step(2);
      chk("t7_hold", 32'(overrun), 32'd1);

      // reset mid-run beats abort and start
      start_run(2, 3, 2);
      step(2);
      reset_in = 1'b0; abort = 1'b1; start = 1'b1;
      step();
      chk("t8_adr", 32'(data_lut_adr), 32'd0);
      chk("t8_flags", 32'({datavalid_out, clear_ena, trunc_ena, busy, done, timeout, overrun}), 32'd0);
      chk("t8_rcnt", 32'(res_count), 32'd0);
      reset_in = 1'b1; abort = 1'b0; start = 1'b0;
      step(2);
      chk("t8_idle", 32'({busy, datavalid_out}), 32'd0);
      chk("t8_queue", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
